// File: rtl/keyrom_reader.sv
// Key ROM read sequencer: fetches KEY_WORDS words from the key ROM behind an access
// grant and streams them over valid/ready through a 2-entry FIFO.
module keyrom_reader #(
    parameter int unsigned ADDR_MSB  = 4,
    parameter int unsigned KEY_WORDS = 4,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                mclk,
    input  logic                puc_rst,
    input  logic                start,
    input  logic                grant,
    output logic [ADDR_MSB:0]   rom_addr,
    output logic                rom_cen,
    input  logic [15:0]         rom_dout,
    output logic [15:0]         key_data,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_last,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned AW = ADDR_MSB + 1;
    localparam int unsigned CW = $clog2(KEY_WORDS) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        issued_q, issued_d;
    logic [CW-1:0]        accepted_q, accepted_d;
    logic                 inflight_q, inflight_d;
    logic [1:0]           occ_q, occ_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [1:0][15:0]     fifo_q, fifo_d;
    logic                 err_q, err_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic                 issue;
    logic                 pop;
    logic                 push;

    // Next-state, FIFO bookkeeping and interface outputs
    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        inflight_d = inflight_q;
        occ_d      = occ_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_d     = fifo_q;
        err_d      = err_q;
        addr_d     = addr_q;
        issue      = 1'b0;
        push       = 1'b0;

        key_valid = (state_q == ST_FETCH) && (occ_q != 2'd0);
        key_data  = key_valid ? fifo_q[rd_ptr_q] : 16'h0000;
        key_last  = key_valid && (accepted_q == CW'(KEY_WORDS - 1));
        pop       = key_valid && key_ready;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (grant) begin
                        state_d    = ST_FETCH;
                        err_d      = 1'b0;
                        issued_d   = '0;
                        accepted_d = '0;
                        inflight_d = 1'b0;
                        occ_d      = '0;
                        rd_ptr_d   = 1'b0;
                        wr_ptr_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (!grant) begin
                    // Abort: scrub buffered key material and drop the pending read
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    inflight_d = 1'b0;
                    occ_d      = '0;
                    rd_ptr_d   = 1'b0;
                    wr_ptr_d   = 1'b0;
                    fifo_d     = '0;
                end else begin
                    issue = (issued_q < CW'(KEY_WORDS)) &&
                            ((3'(occ_q) + 3'(inflight_q) - 3'(pop)) < 3'd2);
                    push       = inflight_q;
                    inflight_d = issue;
                    if (issue) begin
                        issued_d = issued_q + CW'(1);
                        addr_d   = AW'(BASE_ADDR) + AW'(issued_q);
                    end
                    if (push) begin
                        fifo_d[wr_ptr_q] = rom_dout;
                        wr_ptr_d         = ~wr_ptr_q;
                    end
                    if (pop) begin
                        rd_ptr_d   = ~rd_ptr_q;
                        accepted_d = accepted_q + CW'(1);
                        if (accepted_q == CW'(KEY_WORDS - 1)) begin
                            state_d = ST_DONE;
                        end
                    end
                    occ_d = occ_q + 2'(push) - 2'(pop);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rom_cen  = ~issue;
        rom_addr = addr_d;
        busy     = (state_q == ST_FETCH);
        done     = (state_q == ST_DONE);
        err      = err_q;
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q    <= ST_IDLE;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            occ_q      <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fifo_q     <= '0;
            err_q      <= 1'b0;
            addr_q     <= AW'(BASE_ADDR);
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_q     <= fifo_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
        end
    end

endmodule
